// File: rtl/spi_peripheral_pkg.sv
// Shared SPI peripheral definitions: mode decoding, byte geometry, FSM states
// and the fill value shifted out when nothing was staged.
package spi_pkg;

    localparam int BITS_PER_BYTE = 8;
    localparam int BIT_CNT_W     = $clog2(BITS_PER_BYTE);

    localparam logic [BITS_PER_BYTE-1:0] TX_UNDERRUN_FILL = 8'h00;

    typedef enum logic {
        SPI_IDLE,
        SPI_ACTIVE
    } spi_state_e;

    function automatic logic spi_cpol(input int mode);
        return mode[1];
    endfunction

    function automatic logic spi_cpha(input int mode);
        return mode[0];
    endfunction

endpackage

// File: rtl/spi_peripheral_if.sv
// Pin-side and byte-side signals of the SPI peripheral. The slave modport is the
// peripheral's view; the master modport is the controller/host view.
interface spi_peripheral_if;
    import spi_pkg::*;

    logic                     i_spi_clk;
    logic                     i_spi_cs_n;
    logic                     i_spi_copi;
    logic                     o_spi_cipo;
    logic [BITS_PER_BYTE-1:0] o_rx_byte;
    logic                     o_rx_dv;
    logic [BITS_PER_BYTE-1:0] i_tx_byte;
    logic                     i_tx_dv;
    logic                     o_tx_ready;

    modport slave (
        input  i_spi_clk, i_spi_cs_n, i_spi_copi, i_tx_byte, i_tx_dv,
        output o_spi_cipo, o_rx_byte, o_rx_dv, o_tx_ready
    );

    modport master (
        output i_spi_clk, i_spi_cs_n, i_spi_copi, i_tx_byte, i_tx_dv,
        input  o_spi_cipo, o_rx_byte, o_rx_dv, o_tx_ready
    );

endinterface

// File: rtl/spi_input_sync.sv
// Two-flop synchronizer for one asynchronous input, with a synchronous reset
// to a caller-chosen idle level so no false edge follows reset.
module spi_input_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/spi_peripheral.sv
// Byte-oriented SPI responder, modes 0-3, oversampled on i_clk.
// Define SPI_PERIPHERAL_SYNC_EN to put 2-flop synchronizers on SCLK/CS_n/COPI.
module spi_peripheral
    import spi_pkg::*;
#(
    parameter int SPI_MODE = 0
) (
    input  logic            i_clk,
    input  logic            i_reset,
    spi_peripheral_if.slave bus
);

    localparam logic CPOL = spi_cpol(SPI_MODE);
    localparam logic CPHA = spi_cpha(SPI_MODE);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(BITS_PER_BYTE - 1);

    logic sclk_s, cs_n_s, copi_s;

`ifdef SPI_PERIPHERAL_SYNC_EN
    spi_input_sync #(.RST_VAL(CPOL)) u_sync_sclk (
        .clk_i(i_clk), .rst_i(i_reset), .d_i(bus.i_spi_clk), .q_o(sclk_s)
    );
    spi_input_sync #(.RST_VAL(1'b1)) u_sync_cs_n (
        .clk_i(i_clk), .rst_i(i_reset), .d_i(bus.i_spi_cs_n), .q_o(cs_n_s)
    );
    spi_input_sync #(.RST_VAL(1'b0)) u_sync_copi (
        .clk_i(i_clk), .rst_i(i_reset), .d_i(bus.i_spi_copi), .q_o(copi_s)
    );
`else
    assign sclk_s = bus.i_spi_clk;
    assign cs_n_s = bus.i_spi_cs_n;
    assign copi_s = bus.i_spi_copi;
`endif

    logic                     sclk_q, sclk_prev_q, cs_n_q, cs_n_prev_q, copi_q;
    spi_state_e               state_q, state_d;
    logic [BIT_CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [BITS_PER_BYTE-2:0] rx_shift_q, rx_shift_d;
    logic [BITS_PER_BYTE-1:0] tx_shift_q, tx_shift_d;
    logic                     cipo_q, cipo_d;
    logic [BITS_PER_BYTE-1:0] rx_byte_q, rx_byte_d;
    logic                     rx_dv_q, rx_dv_d;
    logic [BITS_PER_BYTE-1:0] tx_buf_q, tx_buf_d;
    logic                     tx_full_q, tx_full_d;

    logic sclk_rise, sclk_fall, lead_edge, trail_edge, sample_edge, shift_edge;
    logic cs_fall, cs_rise;
    logic byte_start;
    logic [BITS_PER_BYTE-1:0] load_byte;

    assign sclk_rise   = sclk_q & ~sclk_prev_q;
    assign sclk_fall   = ~sclk_q & sclk_prev_q;
    assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
    assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;
    assign cs_fall     = ~cs_n_q & cs_n_prev_q;
    assign cs_rise     = cs_n_q & ~cs_n_prev_q;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        cipo_d     = cipo_q;
        rx_byte_d  = rx_byte_q;
        rx_dv_d    = 1'b0;
        tx_buf_d   = tx_buf_q;
        tx_full_d  = tx_full_q;
        byte_start = 1'b0;
        load_byte  = tx_full_q ? tx_buf_q : TX_UNDERRUN_FILL;

        case (state_q)
            SPI_IDLE: begin
                bit_cnt_d  = '0;
                rx_shift_d = '0;
                tx_shift_d = '0;
                cipo_d     = 1'b0;
                if (cs_fall) begin
                    state_d    = SPI_ACTIVE;
                    byte_start = 1'b1;
                end
            end
            SPI_ACTIVE: begin
                if (cs_rise) begin
                    state_d    = SPI_IDLE;
                    bit_cnt_d  = '0;
                    rx_shift_d = '0;
                    tx_shift_d = '0;
                    cipo_d     = 1'b0;
                end else begin
                    if (sample_edge) begin
                        rx_shift_d = {rx_shift_q[BITS_PER_BYTE-3:0], copi_q};
                        bit_cnt_d  = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == LAST_BIT) begin
                            rx_byte_d  = {rx_shift_q, copi_q};
                            rx_dv_d    = 1'b1;
                            byte_start = 1'b1;
                        end
                    end
                    // In CPHA=0 the MSB is already on CIPO at byte start, so the
                    // trailing edge right after a byte boundary must not advance.
                    if (shift_edge && (CPHA || bit_cnt_q != '0)) begin
                        cipo_d     = tx_shift_q[BITS_PER_BYTE-1];
                        tx_shift_d = tx_shift_q << 1;
                    end
                end
            end
            default: state_d = SPI_IDLE;
        endcase

        // tx_shift holds only the bits not yet driven onto CIPO.
        if (byte_start) begin
            tx_full_d = 1'b0;
            if (CPHA) begin
                tx_shift_d = load_byte;
            end else begin
                cipo_d     = load_byte[BITS_PER_BYTE-1];
                tx_shift_d = {load_byte[BITS_PER_BYTE-2:0], 1'b0};
            end
        end

        if (bus.i_tx_dv && !tx_full_q) begin
            tx_buf_d  = bus.i_tx_byte;
            tx_full_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sclk_q      <= CPOL;
            sclk_prev_q <= CPOL;
            cs_n_q      <= 1'b1;
            cs_n_prev_q <= 1'b1;
            copi_q      <= 1'b0;
            state_q     <= SPI_IDLE;
            bit_cnt_q   <= '0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            cipo_q      <= 1'b0;
            rx_byte_q   <= '0;
            rx_dv_q     <= 1'b0;
            tx_buf_q    <= '0;
            tx_full_q   <= 1'b0;
        end else begin
            sclk_q      <= sclk_s;
            sclk_prev_q <= sclk_q;
            cs_n_q      <= cs_n_s;
            cs_n_prev_q <= cs_n_q;
            copi_q      <= copi_s;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            cipo_q      <= cipo_d;
            rx_byte_q   <= rx_byte_d;
            rx_dv_q     <= rx_dv_d;
            tx_buf_q    <= tx_buf_d;
            tx_full_q   <= tx_full_d;
        end
    end

    assign bus.o_spi_cipo = cipo_q;
    assign bus.o_rx_byte  = rx_byte_q;
    assign bus.o_rx_dv    = rx_dv_q;
    assign bus.o_tx_ready = ~tx_full_q;

endmodule

// File: tb/tb_spi_peripheral.sv
// Bench: one peripheral per SPI mode, bit-banged controller, queue/buffer model
// of the byte-level behaviour checked every cycle plus literal spot checks.
module tb_spi_peripheral;

    localparam int HALF = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       sclk [4];
    logic       cs_n [4];
    logic       copi [4];
    logic       tx_dv [4];
    logic [7:0] tx_byte [4];
    logic       cipo [4];
    logic [7:0] rx_byte [4];
    logic       rx_dv [4];
    logic       tx_ready [4];

    int checks = 0;
    int errors = 0;
    bit busy = 1'b1;

    // Model: staging buffer per mode, and expected received bytes as {mode, byte}.
    logic       mfull [4];
    logic [7:0] mbuf [4];
    logic [9:0] rxq [$];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_peripheral_if bus ();
        assign bus.i_spi_clk  = sclk[g];
        assign bus.i_spi_cs_n = cs_n[g];
        assign bus.i_spi_copi = copi[g];
        assign bus.i_tx_byte  = tx_byte[g];
        assign bus.i_tx_dv    = tx_dv[g];
        assign cipo[g]        = bus.o_spi_cipo;
        assign rx_byte[g]     = bus.o_rx_byte;
        assign rx_dv[g]       = bus.o_rx_dv;
        assign tx_ready[g]    = bus.o_tx_ready;

        spi_peripheral #(.SPI_MODE(g)) dut (
            .i_clk  (clk),
            .i_reset(rst),
            .bus    (bus.slave)
        );
    end

    task automatic chk(input string nm, input int m, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s mode %0d got 0x%0h want 0x%0h", nm, m, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [7:0] consume(input int m);
        logic [7:0] b;
        b = mfull[m] ? mbuf[m] : 8'h00;
        mfull[m] = 1'b0;
        return b;
    endfunction

    task automatic stage(input int m, input logic [7:0] b);
        tx_byte[m] = b;
        tx_dv[m]   = 1'b1;
        if (!mfull[m]) begin
            mbuf[m]  = b;
            mfull[m] = 1'b1;
        end
        @(negedge clk);
        tx_dv[m] = 1'b0;
    endtask

    task automatic settle(input int n);
        wait_cyc(6);
        busy = 1'b0;
        wait_cyc(n);
        busy = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        rxq.delete();
        for (int m = 0; m < 4; m++) mfull[m] = 1'b0;
        @(posedge clk);
        #1;
        for (int m = 0; m < 4; m++) begin
            chk("rst_rx_byte", m, 32'(rx_byte[m]), 32'h00);
            chk("rst_rx_dv", m, 32'(rx_dv[m]), 32'd0);
            chk("rst_tx_ready", m, 32'(tx_ready[m]), 32'd1);
            chk("rst_cipo", m, 32'(cipo[m]), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Clocks nbits of one byte with CS already low; SCLK starts and ends at CPOL.
    task automatic clock_byte(input int m, input logic [7:0] mosi, input int nbits,
                              input bit stg, input logic [7:0] stgv,
                              output logic [7:0] miso, output logic [7:0] next_tx);
        logic cpol, cpha;
        cpol = m[1];
        cpha = m[0];
        miso = 8'h00;
        next_tx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            if (!cpha) begin
                copi[m] = mosi[7-i];
                wait_cyc(HALF);
                miso[7-i] = cipo[m];
                sclk[m] = ~cpol;
                if (i == 7) begin
                    rxq.push_back({2'(m), mosi});
                    next_tx = consume(m);
                end
                wait_cyc(HALF);
                sclk[m] = cpol;
            end else begin
                sclk[m] = ~cpol;
                copi[m] = mosi[7-i];
                wait_cyc(HALF);
                miso[7-i] = cipo[m];
                sclk[m] = cpol;
                if (i == 7) begin
                    rxq.push_back({2'(m), mosi});
                    next_tx = consume(m);
                end
                wait_cyc(HALF);
            end
            if (i == 2 && stg) stage(m, stgv);
        end
    endtask

    task automatic transfer(input int m, input int nbytes, input int last_bits,
                            input logic [7:0] mosi [4], input bit stg [4],
                            input logic [7:0] stgv [4], output logic [7:0] miso [4]);
        logic [7:0] exp_tx, nxt, got;
        int nb;
        for (int k = 0; k < 4; k++) miso[k] = 8'h00;
        cs_n[m] = 1'b0;
        exp_tx = consume(m);
        wait_cyc(HALF);
        for (int k = 0; k < nbytes; k++) begin
            nb = (k == nbytes - 1) ? last_bits : 8;
            clock_byte(m, mosi[k], nb, stg[k], stgv[k], got, nxt);
            miso[k] = got;
            if (nb == 8) begin
                chk("cipo_byte", m, 32'(got), 32'(exp_tx));
                exp_tx = nxt;
            end
        end
        wait_cyc(HALF);
        cs_n[m] = 1'b1;
        wait_cyc(2 * HALF);
        chk("rx_missing", m, 32'(rxq.size()), 32'd0);
    endtask

    always @(posedge clk) begin
        logic [9:0] e;
        #1;
        for (int m = 0; m < 4; m++) begin
            if (rx_dv[m] === 1'b1) begin
                if (rxq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_dv_unexpected mode %0d got byte 0x%0h want no pulse", m, rx_byte[m]);
                end else begin
                    e = rxq.pop_front();
                    chk("rx_byte", m, {22'd0, 2'(m), rx_byte[m]}, {22'd0, e});
                end
            end
            if (!busy && !rst) begin
                chk("idle_cipo", m, 32'(cipo[m]), 32'd0);
                chk("tx_ready", m, 32'(tx_ready[m]), 32'(!mfull[m]));
            end
        end
    end

    initial begin
        logic [7:0] mo [4];
        bit         st [4];
        logic [7:0] sv [4];
        logic [7:0] mi [4];
        logic [7:0] got, nxt, tmp;
        int m, nb, lb;

        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            sclk[k] = (k >= 2);
            cs_n[k] = 1'b1;
            copi[k] = 1'b0;
            tx_dv[k] = 1'b0;
            tx_byte[k] = 8'h00;
            mfull[k] = 1'b0;
            mbuf[k] = 8'h00;
            st[k] = 1'b0;
            sv[k] = 8'h00;
            mo[k] = 8'h00;
        end
        do_reset();
        settle(4);

        // Mode 0: stage A5, receive 3C
        stage(0, 8'hA5);
        settle(4);
        mo[0] = 8'h3C;
        transfer(0, 1, 8, mo, st, sv, mi);
        chk("m0_cipo_lit", 0, 32'(mi[0]), 32'hA5);
        settle(4);
        chk("m0_rx_lit", 0, 32'(rx_byte[0]), 32'h3C);

        // Mode 3: two back-to-back bytes, second staged mid-byte
        stage(3, 8'h12);
        mo[0] = 8'h81; mo[1] = 8'h7E;
        st[0] = 1'b1; sv[0] = 8'h34;
        transfer(3, 2, 8, mo, st, sv, mi);
        st[0] = 1'b0;
        chk("m3_cipo0_lit", 3, 32'(mi[0]), 32'h12);
        chk("m3_cipo1_lit", 3, 32'(mi[1]), 32'h34);
        settle(4);
        chk("m3_rx_lit", 3, 32'(rx_byte[3]), 32'h7E);

        // Mode 1: underrun
        mo[0] = 8'h96;
        transfer(1, 1, 8, mo, st, sv, mi);
        chk("m1_underrun_lit", 1, 32'(mi[0]), 32'h00);
        settle(4);
        chk("m1_rx_lit", 1, 32'(rx_byte[1]), 32'h96);

        // Mode 0: CS aborts after 5 bits with a byte staged mid-way, then F0
        mo[0] = 8'hFF; st[0] = 1'b1; sv[0] = 8'h69;
        transfer(0, 1, 5, mo, st, sv, mi);
        st[0] = 1'b0;
        settle(4);
        mo[0] = 8'hF0;
        transfer(0, 1, 8, mo, st, sv, mi);
        chk("m0_retained_lit", 0, 32'(mi[0]), 32'h69);
        settle(4);
        chk("m0_rx_f0_lit", 0, 32'(rx_byte[0]), 32'hF0);

        // Mode 2: second stage while full is ignored
        stage(2, 8'h55);
        stage(2, 8'hAA);
        settle(4);
        mo[0] = 8'h5A;
        transfer(2, 1, 8, mo, st, sv, mi);
        chk("m2_ignore_lit", 2, 32'(mi[0]), 32'h55);
        settle(4);

        // Mode 2: reset mid-byte, then a clean transfer
        cs_n[2] = 1'b0;
        tmp = consume(2);
        wait_cyc(HALF);
        clock_byte(2, 8'hE7, 4, 1'b0, 8'h00, got, nxt);
        do_reset();
        wait_cyc(HALF);
        cs_n[2] = 1'b1;
        wait_cyc(2 * HALF);
        settle(4);
        mo[0] = 8'hC3;
        transfer(2, 1, 8, mo, st, sv, mi);
        settle(4);
        chk("m2_rx_c3_lit", 2, 32'(rx_byte[2]), 32'hC3);

        // Randomized transfers
        for (int it = 0; it < 14; it++) begin
            m  = $urandom_range(0, 3);
            nb = $urandom_range(1, 3);
            lb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 8;
            for (int k = 0; k < 4; k++) begin
                mo[k] = 8'($urandom);
                st[k] = 1'($urandom_range(0, 1));
                sv[k] = 8'($urandom);
            end
            if ($urandom_range(0, 1) == 1) stage(m, 8'($urandom));
            if ($urandom_range(0, 2) == 0) stage(m, 8'($urandom));
            transfer(m, nb, lb, mo, st, sv, mi);
            settle(4);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_peripheral.md
# spi_peripheral

Byte-oriented SPI peripheral (responder): the far end of the team's SPI controller. It oversamples SCLK, CS_n and COPI on the system clock and shifts received bits MSB-first into a byte, which it presents with a one-cycle valid pulse. In the same transfer it shifts a staged transmit byte out on CIPO. It sits between the external SPI pins and the register/command logic of a peripheral design.

## Interface

- SPI_MODE, 0: SPI mode 0–3. CPOL = SPI_MODE[1], CPHA = SPI_MODE[0].
- i_clk  input  1  system clock. All logic is on its rising edge.
- i_reset  input  1  reset, synchronous and active-high.
- i_spi_clk  input  1  SCLK from the controller. Asynchronous to i_clk.
- i_spi_cs_n  input  1  chip select, active-low. Asynchronous.
- i_spi_copi  input  1  controller-out, peripheral-in data.
- o_spi_cipo  output  1  controller-in, peripheral-out data.
- o_rx_byte  output  8  last complete received byte.
- o_rx_dv  output  1  one-cycle pulse when o_rx_byte updates.
- i_tx_byte  input  8  next byte to transmit.
- i_tx_dv  input  1  pulse that stages i_tx_byte. Accepted only while o_tx_ready=1.
- o_tx_ready  output  1  1 when the transmit staging buffer is empty.

## Operation

- **Edge detection.** The registered SCLK is compared with its previous value.
  - Leading edge = transition away from CPOL.
  - Trailing edge = transition back to CPOL.
  - Sample edge = leading edge if CPHA=0, trailing edge if CPHA=1. Shift edge is the other one.
- **State machine.**
  - IDLE: CS_n high. Bit counter = 0. CIPO driven 0.
  - ACTIVE: CS_n low.
  - IDLE→ACTIVE on the registered CS_n falling. ACTIVE→IDLE on the registered CS_n rising.
- **Byte start** (entering ACTIVE, or the sample edge completing bit 7 while CS_n stays low):
  - The tx shift register loads the staging buffer if it is full, otherwise 0x00 (underrun).
  - The buffer empties.
- **CIPO drive.**
  - CPHA=0: CIPO = shift-register MSB immediately at byte start. Each shift edge advances one bit.
  - CPHA=1: CIPO updates on each shift edge, starting with the MSB on the first leading edge.
- **Receive.**
  - Each sample edge shifts COPI into the rx shift register LSB and increments the 3-bit bit counter, which wraps 7→0.
  - On the 8th sample edge: o_rx_byte <= assembled byte, o_rx_dv=1 for exactly one cycle.
- **Transmit handshake.**
  - i_tx_dv with o_tx_ready=1 stages i_tx_byte, and o_tx_ready falls the next cycle.
  - i_tx_dv with o_tx_ready=0 is ignored: the buffer is not overwritten.
  - o_tx_ready rises the cycle after the buffer is consumed at byte start.
  - Staging is permitted in any state.
- **CS_n deasserted mid-byte.**
  - The partial rx byte is discarded with no o_rx_dv.
  - The bit counter clears and the tx shift register clears.
  - A staging buffer that was not yet consumed is retained.
- **Simultaneous i_tx_dv and byte-start consumption in the same cycle.** The consumption sees the old buffer state, then the new byte is staged. If the buffer was full, i_tx_dv is ignored as normal.
- **Reset (any time, including mid-transfer).** State IDLE; o_rx_byte=0x00, o_rx_dv=0, o_tx_ready=1, o_spi_cipo=0; shift registers, bit counter and staging buffer cleared.

## Timing

- Input path latency, from a pin change to detected edge: 3 cycles with synchronizers, 1 cycle without.
- SCLK high and low phases must each be ≥4 i_clk cycles with synchronizers, ≥2 without.
- CS_n must fall ≥4 i_clk cycles before the first SCLK edge and rise ≥4 cycles after the last one.
- o_rx_dv asserts 1 cycle after the 8th sample edge is detected.
- o_spi_cipo updates 1 cycle after the shift edge is detected. It is registered with no combinational path from any input.
- Back-to-back bytes within one CS_n assertion are supported with no gap cycles. Software must stage each next byte before the 8th sample edge of the current byte.

## Configuration

- SPI_PERIPHERAL_SYNC_EN
  - Defined: i_spi_clk, i_spi_cs_n and i_spi_copi each pass through a 2-flop synchronizer before edge detection. Latency and minimum SCLK phase are as above.
  - Undefined: inputs feed the edge-detect register directly. This is for simulation or same-clock-domain controllers only. All behaviour other than the latency is identical.

## Structure

- Shared package spi_pkg:
  - CPOL/CPHA extraction functions from SPI_MODE.
  - BITS_PER_BYTE = 8.
  - State enum {SPI_IDLE, SPI_ACTIVE}.
  - Underrun fill value 0x00.
- Sub-module spi_input_sync: 2-flop synchronizer, 1 bit, with synchronous reset. Instantiated three times under SPI_PERIPHERAL_SYNC_EN.

## Test plan

- Mode 0, stage 0xA5, CS_n low, controller sends 0x3C -> CIPO carries 0xA5 MSB-first; o_rx_byte=0x3C; one o_rx_dv pulse; o_tx_ready low then high after CS fall.
- Mode 3, two bytes in one CS: 0x81 then 0x7E on COPI, 0x12 then 0x34 staged -> rx_dv twice with 0x81 and 0x7E; CIPO carries 0x12 then 0x34 with no gap.
- Mode 1, nothing staged -> CIPO outputs 0x00 (underrun); rx still captured.
- CS_n rises after 5 bits, then a full byte 0xF0 -> no rx_dv for the partial byte; next rx byte = 0xF0; an unconsumed staged byte is sent.
- i_tx_dv 0x55 then 0xAA with no byte start in between -> 0xAA ignored; 0x55 transmitted.
- i_reset pulse mid-byte in mode 2 -> all outputs at reset values the next cycle; a subsequent transfer of 0xC3 is received correctly.
